// File: rtl/p_xfer_seq.sv
// Parasite-side transfer sequencer for Tube register 3: moves bytes between
// parasite memory and the register 3 FIFO pair for one transfer type at a time.
module p_xfer_seq #(
  parameter int ADDR_W    = 16,
  parameter int BLOCK_LEN = 256
) (
  input  logic              p_phi2,
  input  logic              h_rst_b,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        xfer_type,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              fifo_full,
  input  logic              fifo_avail,
  input  logic [7:0]        fifo_rdata,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdata,
  output logic              fifo_rd,
  output logic              one_byte_mode,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [8:0]        byte_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [8:0]        BLOCK_CNT = BLOCK_LEN[8:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_RD_MEM,
    S_PUSH,
    S_WAIT_DATA,
    S_POP,
    S_WR_MEM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic              second_q, second_d;
  logic [7:0]        data_q, data_d;
  logic              obm_q, obm_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pair_mode;
  logic              block_mode;
  logic [ADDR_W-1:0] addr_inc;
  logic [8:0]        cnt_inc;
  state_t            resume_state;
  state_t            end_state;

  assign pair_mode    = (type_q[2:1] == 2'b01);
  assign block_mode   = (type_q[2:1] == 2'b11);
  assign addr_inc     = addr_q + ADDR_ONE;
  assign cnt_inc      = cnt_q + 9'd1;
  assign resume_state = type_q[0] ? S_WAIT_DATA : S_WAIT_SPACE;

  // Unit-boundary decision; a stop arriving on the boundary cycle itself counts.
  always_comb begin
    end_state = resume_state;
    if (block_mode) begin
      if (cnt_inc == BLOCK_CNT) end_state = S_DONE;
    end else if (stop_q || stop) begin
      end_state = S_DONE;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    type_d   = type_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    second_d = second_q;
    data_d   = data_q;
    obm_d    = obm_q;

    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          type_d   = xfer_type;
          addr_d   = start_addr;
          cnt_d    = 9'd0;
          stop_d   = 1'b0;
          second_d = 1'b0;
          obm_d    = (xfer_type[2:1] != 2'b01);
          if (xfer_type[2:1] == 2'b10) state_d = S_DONE;
          else if (xfer_type[0])       state_d = S_WAIT_DATA;
          else                         state_d = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: if (!fifo_full) state_d = S_RD_MEM;
      S_RD_MEM: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        addr_d = addr_inc;
        cnt_d  = cnt_inc;
        // The second byte of a pair is fetched without rechecking fifo_full.
        if (pair_mode && !second_q) begin
          second_d = 1'b1;
          state_d  = S_RD_MEM;
        end else begin
          second_d = 1'b0;
          state_d  = end_state;
        end
      end
      S_WAIT_DATA: if (fifo_avail) state_d = S_POP;
      S_POP: begin
        data_d  = fifo_rdata;
        state_d = S_WR_MEM;
      end
      S_WR_MEM: begin
        if (mem_ack) begin
          addr_d = addr_inc;
          cnt_d  = cnt_inc;
          if (pair_mode && !second_q) begin
            second_d = 1'b1;
            state_d  = S_POP;
          end else begin
            second_d = 1'b0;
            state_d  = end_state;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is a clean flop.
  always_comb begin
    fifo_wr_d = (state_d == S_PUSH);
    fifo_rd_d = (state_d == S_POP);
    mem_req_d = (state_d == S_RD_MEM) || (state_d == S_WR_MEM);
    mem_we_d  = (state_d == S_WR_MEM);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q   <= S_IDLE;
      type_q    <= 3'd0;
      addr_q    <= '0;
      cnt_q     <= 9'd0;
      stop_q    <= 1'b0;
      second_q  <= 1'b0;
      data_q    <= 8'd0;
      obm_q     <= 1'b1;
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      second_q  <= second_d;
      data_q    <= data_d;
      obm_q     <= obm_d;
      fifo_wr_q <= fifo_wr_d;
      fifo_rd_q <= fifo_rd_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_wr       = fifo_wr_q;
  assign fifo_wdata    = data_q;
  assign fifo_rd       = fifo_rd_q;
  assign one_byte_mode = obm_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign byte_count    = cnt_q;

endmodule

// File: doc/p_xfer_seq.md
Name: p_xfer_seq

Overview:
- Parasite-side transfer sequencer for Tube register 3.
- Runs one Tube transfer type (0-7) at a time. It moves bytes between parasite memory and the register 3 FIFOs: memory to the P->H FIFO, or the H->P FIFO to memory.
- Drives the FIFO one_byte_mode (V flag), generates FIFO write/read strobes, counts bytes and ends 256-byte transfers by itself.
- Sits between the parasite memory bus and the register 3 FIFO pair, clocked in the parasite domain.

Parameters:
ADDR_W, 16, parasite memory address width
BLOCK_LEN, 256, byte count for block types 6/7

Ports:
p_phi2  in  1  parasite clock, all state updates on posedge
h_rst_b  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin transfer
stop  in  1  one-cycle pulse: end open-ended transfer (types 0-3)
xfer_type  in  3  Tube transfer type, sampled with start
start_addr  in  ADDR_W  first memory address, sampled with start
fifo_full  in  1  P->H FIFO p_full (mode-qualified)
fifo_avail  in  1  H->P FIFO parasite data-available (mode-qualified)
fifo_rdata  in  8  H->P FIFO read data
fifo_wr  out  1  one-cycle write strobe to P->H FIFO
fifo_wdata  out  8  write data to P->H FIFO
fifo_rd  out  1  one-cycle read strobe to H->P FIFO
one_byte_mode  out  1  V flag to both FIFOs
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read, valid with mem_req
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, valid with mem_ack
mem_ack  in  1  memory cycle complete
busy  out  1  transfer active
done  out  1  one-cycle pulse at transfer end
byte_count  out  9  bytes moved in current or last transfer

Behaviour:
- Reset (async, h_rst_b low): state IDLE. one_byte_mode=1, byte_count=0, address=0, latched stop cleared. All other outputs are 0.
- Reset mid-transfer abandons the transfer immediately; no done pulse.
- Type decode:
  - Types 0, 2, 6 are P->H. Types 1, 3, 7 are H->P.
  - Types 2/3 use pairs: one_byte_mode=0, unit = 2 bytes. All other types use one_byte_mode=1, unit = 1 byte.
  - Types 4/5 are no-ops: IDLE -> DONE, byte_count=0, no FIFO or memory activity.
- one_byte_mode updates on the cycle start is accepted and holds until the next accepted start.
- IDLE: busy=0.
  - start=1: latch type, address and mode; clear byte_count and stop latch; go to WAIT next cycle, so busy rises one cycle after start.
  - start while busy is ignored. stop while idle is ignored.
- P->H path:
  - WAIT_SPACE: when fifo_full=0, go to RD_MEM.
  - RD_MEM: mem_req=1, mem_we=0, mem_addr=current address, held until mem_ack. On mem_ack, capture mem_rdata and go to PUSH.
  - PUSH: fifo_wr=1 for exactly one cycle, with fifo_wdata=captured byte. Address increments and byte_count increments.
  - In pair mode, after the first byte of a unit go straight to RD_MEM; fifo_full is not rechecked. Otherwise go to the end check.
- H->P path:
  - WAIT_DATA: when fifo_avail=1, go to POP.
  - POP: fifo_rd=1 for one cycle; capture fifo_rdata in the same cycle. Go to WR_MEM.
  - WR_MEM: mem_req=1, mem_we=1, mem_wdata=captured byte, held until mem_ack. On ack, address and byte_count increment.
  - In pair mode, after the first byte go straight to POP (avail stays high until both bytes are removed). Otherwise go to the end check.
- End check, after each complete unit:
  - Types 6/7: when byte_count==BLOCK_LEN, go to DONE.
  - Types 0-3: if the stop latch is set, go to DONE; otherwise go back to WAIT.
- stop arriving mid-unit is latched and honoured only at the unit boundary; a pair is never split.
- DONE: done=1 for one cycle, then IDLE. byte_count holds its final value until the next start.
- Arithmetic:
  - Address wraps modulo 2^ADDR_W (0xFFFF -> 0x0000).
  - byte_count wraps modulo 512 for open-ended types.
- Simultaneous events:
  - stop in the same cycle as start is ignored.
  - mem_ack may arrive in the first cycle mem_req is high.
  - mem_req drops the cycle after ack.
- At most one of fifo_wr / fifo_rd / mem_req is active per cycle.

Test Plan:
- Type 6, start_addr=0x1200, memory = pattern, mem_ack one cycle after req, fifo_full=0 -> 256 fifo_wr pulses with data matching memory 0x1200-0x12FF in order. byte_count=256, one done pulse, busy low after.
- Type 2, fifo_full toggled high between pairs, stop during the first byte of the third pair -> one_byte_mode=0, exactly 6 bytes written in back-to-back pairs. No read starts while fifo_full=1; done after byte 6.
- Type 7, fifo_avail held high, fifo_rdata counting 0x00.. -> 256 memory writes with mem_we=1, addresses start_addr..+255, data 0x00..0xFF, 256 fifo_rd pulses.
- Type 1, start_addr=0xFFFE, 3 bytes then stop -> write addresses FFFE, FFFF, 0000; one_byte_mode=1.
- Type 4 -> done two cycles after start, byte_count=0, no strobes; a second start during busy of a type 0 run is ignored.
- h_rst_b low during RD_MEM of type 0 -> all outputs 0 immediately, one_byte_mode=1, no done pulse; a new start after release runs normally.
